// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button input path: FSM encodings and
// board clock constants used to size debounce and long-press windows.
package key_debounce_pkg;

  localparam int CLK_HZ        = 27_000_000;
  localparam int CYCLES_PER_MS = CLK_HZ / 1000;
  localparam int CYCLES_PER_S  = CLK_HZ;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    HELD       = 3'd3,
    DB_RELEASE = 3'd4
  } key_state_t;

  function automatic int ms_to_cycles(input int ms);
    return ms * CYCLES_PER_MS;
  endfunction

  localparam int DEBOUNCE_DEFAULT = ms_to_cycles(20);
  localparam int LONG_DEFAULT     = CYCLES_PER_S;

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchronizer for a raw asynchronous pin; the reset value is
// a parameter so the pin powers up reading its inactive level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Debounced push-button: clean level plus single-cycle press, release and
// long-press pulses, all registered, driven by one shared stability counter.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES     = LONG_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Key_in,
  output logic Key_level,
  output logic Key_press,
  output logic Key_release,
  output logic Key_long
);

  localparam int CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level,     w_level_nxt;
  logic             r_press,     w_press_nxt;
  logic             r_release,   w_release_nxt;
  logic             r_long,      w_long_nxt;
  logic             r_long_done, w_long_done_nxt;
  logic             w_key_sync;
  logic             w_act;
  logic             w_db_done;
  logic             w_long_hit;

  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .i_clk (Clock),
    .i_rst (Reset),
    .i_d   (Key_in),
    .o_q   (w_key_sync)
  );

  assign w_act      = w_key_sync ^ ACTIVE_LOW;
  assign w_db_done  = (r_cnt == DB_LAST);
  assign w_long_hit = (r_cnt == LONG_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_long_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_level     <= w_level_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_long      <= w_long_nxt;
      r_long_done <= w_long_done_nxt;
    end
  end

  // Once the long press has fired, a re-debounced glitch lands in HELD so it cannot fire twice.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:       if (w_act) w_state_nxt = DB_PRESS;
      DB_PRESS: begin
        if (!w_act)         w_state_nxt = IDLE;
        else if (w_db_done) w_state_nxt = r_long_done ? HELD : PRESSED;
      end
      PRESSED: begin
        if (!w_act)          w_state_nxt = DB_RELEASE;
        else if (w_long_hit) w_state_nxt = HELD;
      end
      HELD:       if (!w_act) w_state_nxt = DB_RELEASE;
      DB_RELEASE: begin
        if (w_act)          w_state_nxt = DB_PRESS;
        else if (w_db_done) w_state_nxt = IDLE;
      end
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Counter restarts on every state change; terminal compares always leave the state, so it never wraps.
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_level_nxt     = r_level;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_long_nxt      = 1'b0;
    w_long_done_nxt = r_long_done;

    if (w_state_nxt != r_state)
      w_cnt_nxt = '0;
    else if (r_state == DB_PRESS || r_state == PRESSED || r_state == DB_RELEASE)
      w_cnt_nxt = r_cnt + 1'b1;

    case (r_state)
      DB_PRESS: if (w_act && w_db_done) begin
        w_level_nxt = 1'b1;
        w_press_nxt = !r_level;
      end
      PRESSED: if (w_act && w_long_hit) begin
        w_long_nxt      = 1'b1;
        w_long_done_nxt = 1'b1;
      end
      DB_RELEASE: if (!w_act && w_db_done) begin
        w_level_nxt     = 1'b0;
        w_release_nxt   = 1'b1;
        w_long_done_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  assign Key_level   = r_level;
  assign Key_press   = r_press;
  assign Key_release = r_release;
  assign Key_long    = r_long;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: an active-high and an active-low instance,
// expected outputs queued per cycle and compared 1 time unit after each edge.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst0, rst1, k0, k1;
  logic lvl0, prs0, rel0, lng0;
  logic lvl1, prs1, rel1, lng1;

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;
  string sec   = "init";
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  key_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b0)) dut0 (
    .Clock(clk), .Reset(rst0), .Key_in(k0),
    .Key_level(lvl0), .Key_press(prs0), .Key_release(rel0), .Key_long(lng0));

  key_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b1)) dut1 (
    .Clock(clk), .Reset(rst1), .Key_in(k1),
    .Key_level(lvl1), .Key_press(prs1), .Key_release(rel1), .Key_long(lng1));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s %s cyc=%0d {lvl,prs,rel,lng} got=%b want=%b", tag, sec, cyc_no, obs, exp);
      $error("check %s in %s", tag, sec);
    end
  endtask

  // Drive both pins, queue the expected post-edge outputs, clock, then compare.
  task automatic cyc(input logic a, input logic b, input logic [3:0] e0, input logic [3:0] e1);
    logic [7:0] e;
    k0 = a;
    k1 = b;
    exp_q.push_back({e0, e1});
    @(posedge clk);
    #1;
    cyc_no++;
    e = exp_q.pop_front();
    chk("dut0", {lvl0, prs0, rel0, lng0}, e[7:4]);
    chk("dut1", {lvl1, prs1, rel1, lng1}, e[3:0]);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; k0 = 1'b0; k1 = 1'b1;
    #1;

    sec = "reset_toggle";
    for (int i = 0; i < 6; i++) cyc(i[0], !i[0], 4'b0, 4'b0);
    rst0 = 1'b0; rst1 = 1'b0;
    sec = "idle_50";
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, 4'b0, 4'b0);

    // press, long press at 20 cycles after press, glitch after long, no second long
    sec = "press_long";
    for (int i = 1; i <= 60; i++)
      cyc(!(i == 41 || i == 42), 1'b1, {i >= 7, i == 7, 1'b0, i == 27}, 4'b0);
    sec = "release_after_long";
    for (int i = 1; i <= 12; i++) cyc(1'b0, 1'b1, {i < 7, 1'b0, i == 7, 1'b0}, 4'b0);

    sec = "bounce";
    for (int i = 1; i <= 15; i++) cyc(i <= 3, 1'b1, 4'b0, 4'b0);

    // glitch before long: long count restarts when PRESSED is re-entered at edge 19
    sec = "glitch_restart";
    for (int i = 1; i <= 45; i++)
      cyc(!(i == 11 || i == 12), 1'b1, {i >= 7, i == 7, 1'b0, i == 39}, 4'b0);
    sec = "release_after_glitch";
    for (int i = 1; i <= 12; i++) cyc(1'b0, 1'b1, {i < 7, 1'b0, i == 7, 1'b0}, 4'b0);

    sec = "al_press";
    for (int i = 1; i <= 15; i++) cyc(1'b0, 1'b0, 4'b0, {i >= 7, i == 7, 1'b0, 1'b0});
    sec = "al_reset_async";
    rst1 = 1'b1;
    #1;
    chk("dut1_async", {lvl1, prs1, rel1, lng1}, 4'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 4'b0, 4'b0);
    rst1 = 1'b0;
    sec = "al_repress";
    for (int i = 1; i <= 20; i++) cyc(1'b0, 1'b0, 4'b0, {i >= 7, i == 7, 1'b0, 1'b0});
    sec = "al_release";
    for (int i = 1; i <= 12; i++) cyc(1'b0, 1'b1, 4'b0, {i < 7, 1'b0, i == 7, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
